toy_rename_recover_ctrl: RTL and testbench
==========================================

TOY_RENAME_RECOVER_CTRL -- requirements
Module: toy_rename_recover_ctrl

Interface
REQ-001 Parameter MODE, default 0, register class: 0 = INT, 1 = FP.
REQ-002 Parameter RESTORE_WIDTH, default 8, architectural entries restored per cycle; ARCH_ENTRY_NUM SHALL be an integer multiple of it.
REQ-003 clk  input  1  core clock.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 flush_req  input  1  single-cycle pipeline flush request.
REQ-006 commit_inflight  input  1  commit channels still hold older valid commits.
REQ-007 v_reg_backup_phy_id  input  ARCH_ENTRY_NUM x PHY_REG_ID_WIDTH  committed arch-to-phy map from the backup regfile.
REQ-008 rename_stall  output  1  blocks the rename stage.
REQ-009 restore_en  output  1  restore beat valid.
REQ-010 restore_arch_base  output  ARCH_ID_WIDTH  first arch index of the beat.
REQ-011 restore_phy_id  output  RESTORE_WIDTH x PHY_REG_ID_WIDTH  phy ids for arch_base..arch_base+RESTORE_WIDTH-1.
REQ-012 recover_done  output  1  one-cycle pulse when recovery completes.

Function
REQ-013 The FSM SHALL have states IDLE, DRAIN, RESTORE and DONE, encoded as recover_state_e.
REQ-014 IDLE -> DRAIN on flush_req.
REQ-015 DRAIN -> RESTORE in the first cycle where commit_inflight=0; otherwise stay in DRAIN.
REQ-016 In RESTORE, each cycle SHALL do the following:
- assert restore_en;
- drive restore_arch_base = beat_cnt*RESTORE_WIDTH;
- drive restore_phy_id[k] = v_reg_backup_phy_id[base+k], sampled combinationally in the same cycle;
- increment beat_cnt.
REQ-017 RESTORE -> DONE after beat ARCH_ENTRY_NUM/RESTORE_WIDTH-1; DONE SHALL pulse recover_done for one cycle, then go to IDLE.
REQ-018 rename_stall SHALL be 1 in DRAIN, RESTORE and DONE, and 0 only in IDLE.
REQ-019 Latency for flush_req at cycle T with commit_inflight=0: DRAIN at T+1, first beat at T+2, recover_done at T+2+ARCH_ENTRY_NUM/RESTORE_WIDTH.
REQ-020 A flush_req in DRAIN SHALL be absorbed with no state change.
REQ-021 A flush_req in RESTORE or DONE SHALL go to DRAIN next cycle, clear beat_cnt and suppress recover_done.
REQ-022 beat_cnt SHALL be $clog2(ARCH_ENTRY_NUM/RESTORE_WIDTH) bits wide (minimum 1) and SHALL wrap to 0 only via state exit.
REQ-023 restore_arch_base and restore_phy_id SHALL be 0 when restore_en=0.
REQ-024 commit_inflight rising during RESTORE SHALL be ignored; upstream guarantees no new commits after flush.

Reset
REQ-025 Asynchronous reset SHALL force state=IDLE and beat_cnt=0.
REQ-026 During reset all outputs SHALL be 0, including rename_stall, restore_en, restore_arch_base, restore_phy_id and recover_done.
REQ-027 Reset mid-RESTORE SHALL abandon the sequence with no recover_done.
REQ-028 The first flush_req after deassertion SHALL be honoured normally.

Configuration
REQ-029 Macro TOY_RECOVER_PERF_CNT_EN SHALL gate the performance counters.
REQ-030 When TOY_RECOVER_PERF_CNT_EN is defined, the block SHALL add these 32-bit saturating outputs, reset 0:
- perf_flush_cnt: increments on each IDLE->DRAIN transition;
- perf_stall_cycles: increments every cycle rename_stall=1.
REQ-031 When TOY_RECOVER_PERF_CNT_EN is undefined, those ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 recover_state_e and ARCH_ID_WIDTH SHALL live in toy_pack; ARCH_ENTRY_NUM, PHY_REG_ID_WIDTH and PHY_REG_NUM SHALL be reused from toy_pack.
REQ-033 Sub-module toy_rename_recover_beat_mux SHALL hold the combinational beat select, taking v_reg_backup_phy_id and beat_cnt; FSM and counters stay in the top.
REQ-034 One instance SHALL be used per register class (MODE=0 and MODE=1).

Verification
REQ-035 Bench SHALL cover these scenarios (ARCH_ENTRY_NUM=32, RESTORE_WIDTH=8):
- Basic: backup map[i]=i+40, commit_inflight=0, flush_req at T -> 4 beats T+2..T+5 with bases 0, 8, 16, 24 and phy ids 40..71; recover_done at T+6; stall at T+1..T+6.
- Drain hold: commit_inflight=1 for 5 cycles after flush -> restore_en stays 0 throughout, first beat 1 cycle after commit_inflight falls.
- Re-flush: flush_req during beat 2 -> next cycle DRAIN, no recover_done, new sequence restarts at base 0.
- Reset: rst_n low during beat 1 -> all outputs 0 immediately; after release, state IDLE and stall=0.
- Absorb: back-to-back flush_req in DRAIN -> single sequence, single recover_done.
- Perf (macro on): two complete recoveries with no drain wait -> perf_flush_cnt=2, perf_stall_cycles=12.

Source files
------------

// File: rtl/toy_pack.sv
// Shared rename-recovery types and machine-wide sizes.
package toy_pack;

    localparam int ARCH_ENTRY_NUM   = 32;
    localparam int PHY_REG_NUM      = 128;
    localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);
    localparam int ARCH_ID_WIDTH    = $clog2(ARCH_ENTRY_NUM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RESTORE = 2'd2,
        DONE    = 2'd3
    } recover_state_e;

    typedef enum logic {
        REG_CLASS_INT = 1'b0,
        REG_CLASS_FP  = 1'b1
    } reg_class_e;

    // Beat counter width, never narrower than one bit.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/toy_rename_recover_beat_mux.sv
// Selects one restore beat worth of phy ids from the committed backup map.
module toy_rename_recover_beat_mux
    import toy_pack::*;
#(
    parameter int RESTORE_WIDTH = 8,
    parameter int BEAT_W        = 2
) (
    input  logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0] i_v_reg_backup_phy_id,
    input  logic [BEAT_W-1:0]                               i_beat_cnt,
    output logic [ARCH_ID_WIDTH-1:0]                        o_arch_base,
    output logic [RESTORE_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]  o_phy_id
);

    logic [ARCH_ID_WIDTH-1:0] w_idx;

    // Base of the beat and the RESTORE_WIDTH consecutive entries from there.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        o_phy_id    = '0;
        w_idx       = '0;
        o_arch_base = ARCH_ID_WIDTH'(int'(i_beat_cnt) * RESTORE_WIDTH);
        for (int k = 0; k < RESTORE_WIDTH; k++) begin
            w_idx       = o_arch_base + ARCH_ID_WIDTH'(k);
            o_phy_id[k] = i_v_reg_backup_phy_id[w_idx];
        end
    end

endmodule

// File: rtl/toy_rename_recover_ctrl.sv
// Rename-map recovery controller: after a flush, waits for older commits to
// drain, then streams the committed arch-to-phy map back to rename in beats.
// Optional feature: define TOY_RECOVER_PERF_CNT_EN to add saturating
// perf_flush_cnt / perf_stall_cycles outputs.
module toy_rename_recover_ctrl
    import toy_pack::*;
#(
    parameter int MODE          = 0,
    parameter int RESTORE_WIDTH = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           flush_req,
    input  logic                                           commit_inflight,
    input  logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_reg_backup_phy_id,
    output logic                                           rename_stall,
    output logic                                           restore_en,
    output logic [ARCH_ID_WIDTH-1:0]                       restore_arch_base,
    output logic [RESTORE_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] restore_phy_id,
    output logic                                           recover_done
`ifdef TOY_RECOVER_PERF_CNT_EN
    ,
    output logic [31:0]                                    perf_flush_cnt,
    output logic [31:0]                                    perf_stall_cycles
`endif
);

    localparam int BEAT_NUM = ARCH_ENTRY_NUM / RESTORE_WIDTH;
    localparam int BEAT_W   = beat_cnt_width(BEAT_NUM);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEAT_NUM - 1);

    // Register class tag; INT and FP instances share the same datapath.
    localparam reg_class_e unused_reg_class = (MODE != 0) ? REG_CLASS_FP : REG_CLASS_INT;

    recover_state_e    r_state;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_rename_stall;
    logic              r_restore_en;
    logic              r_recover_done;

    logic [ARCH_ID_WIDTH-1:0]                       w_arch_base;
    logic [RESTORE_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] w_phy_id;

    // Recovery FSM with registered stall / beat-valid / done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_beat_cnt     <= '0;
            r_rename_stall <= 1'b0;
            r_restore_en   <= 1'b0;
            r_recover_done <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
            r_recover_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_restore_en <= 1'b0;
                    if (flush_req) begin
                        r_state        <= DRAIN;
                        r_rename_stall <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Further flushes here are absorbed: we are already waiting.
                    if (!commit_inflight) begin
                        r_state      <= RESTORE;
                        r_beat_cnt   <= '0;
                        r_restore_en <= 1'b1;
                    end
                end
                RESTORE: begin
                    // commit_inflight is not looked at: no commits follow a flush.
                    if (flush_req) begin
                        r_state      <= DRAIN;
                        r_beat_cnt   <= '0;
                        r_restore_en <= 1'b0;
                    end else if (r_beat_cnt == LAST_BEAT) begin
                        r_state        <= DONE;
                        r_beat_cnt     <= '0;
                        r_restore_en   <= 1'b0;
                        r_recover_done <= 1'b1;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (flush_req) begin
                        r_state <= DRAIN;
                    end else begin
                        r_state        <= IDLE;
                        r_rename_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_beat_cnt     <= '0;
                    r_rename_stall <= 1'b0;
                    r_restore_en   <= 1'b0;
                end
            endcase
        end
    end

    toy_rename_recover_beat_mux #(
        .RESTORE_WIDTH (RESTORE_WIDTH),
        .BEAT_W        (BEAT_W)
    ) u_beat_mux (
        .i_v_reg_backup_phy_id (v_reg_backup_phy_id),
        .i_beat_cnt            (r_beat_cnt),
        .o_arch_base           (w_arch_base),
        .o_phy_id              (w_phy_id)
    );

    assign rename_stall      = r_rename_stall;
    assign restore_en        = r_restore_en;
    assign restore_arch_base = r_restore_en ? w_arch_base : '0;
    assign restore_phy_id    = r_restore_en ? w_phy_id : '0;
    // A flush landing on the DONE cycle restarts recovery, so the pulse is withheld.
    assign recover_done      = r_recover_done & ~flush_req;

`ifdef TOY_RECOVER_PERF_CNT_EN
    logic [31:0] r_perf_flush_cnt;
    logic [31:0] r_perf_stall_cycles;

    // Saturating flush-entry and stalled-cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_flush_cnt    <= '0;
            r_perf_stall_cycles <= '0;
        end else begin
            if (r_state == IDLE && flush_req && r_perf_flush_cnt != '1)
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            if (r_rename_stall && r_perf_stall_cycles != '1)
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
        end
    end

    assign perf_flush_cnt    = r_perf_flush_cnt;
    assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_toy_rename_recover_ctrl.sv
// Directed bench for toy_rename_recover_ctrl (32 arch entries, 8 per beat).
module tb_toy_rename_recover_ctrl;
    import toy_pack::*;

    localparam int RW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_req;
    logic commit_inflight;
    logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0] backup;

    logic                           stall, en, done;
    logic [ARCH_ID_WIDTH-1:0]       base;
    logic [RW-1:0][PHY_REG_ID_WIDTH-1:0] phy;

    logic                           fp_stall, fp_en, fp_done;
    logic [ARCH_ID_WIDTH-1:0]       fp_base;
    logic [RW-1:0][PHY_REG_ID_WIDTH-1:0] fp_phy;

`ifdef TOY_RECOVER_PERF_CNT_EN
    logic [31:0] perf_flush, perf_stall, fp_perf_flush, fp_perf_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    toy_rename_recover_ctrl #(.MODE(0), .RESTORE_WIDTH(RW)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_req           (flush_req),
        .commit_inflight     (commit_inflight),
        .v_reg_backup_phy_id (backup),
        .rename_stall        (stall),
        .restore_en          (en),
        .restore_arch_base   (base),
        .restore_phy_id      (phy),
        .recover_done        (done)
`ifdef TOY_RECOVER_PERF_CNT_EN
        ,
        .perf_flush_cnt      (perf_flush),
        .perf_stall_cycles   (perf_stall)
`endif
    );

    toy_rename_recover_ctrl #(.MODE(1), .RESTORE_WIDTH(RW)) u_dut_fp (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_req           (flush_req),
        .commit_inflight     (commit_inflight),
        .v_reg_backup_phy_id (backup),
        .rename_stall        (fp_stall),
        .restore_en          (fp_en),
        .restore_arch_base   (fp_base),
        .restore_phy_id      (fp_phy),
        .recover_done        (fp_done)
`ifdef TOY_RECOVER_PERF_CNT_EN
        ,
        .perf_flush_cnt      (fp_perf_flush),
        .perf_stall_cycles   (fp_perf_stall)
`endif
    );

    // Advance one cycle and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0][PHY_REG_ID_WIDTH-1:0] beat_ids(input int b);
        logic [RW-1:0][PHY_REG_ID_WIDTH-1:0] v;
        for (int k = 0; k < RW; k++) v[k] = PHY_REG_ID_WIDTH'(40 + b + k);
        return v;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        flush_req = 1'b0;
        commit_inflight = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush_req = 1'b1;
        commit_inflight = 1'b0;
        for (int i = 0; i < ARCH_ENTRY_NUM; i++) backup[i] = PHY_REG_ID_WIDTH'(i + 40);
        step();
        n_tests++;
        if ({stall, en, base, phy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b en=%b base=%0d done=%b, want all 0", stall, en, base, done);
        end
        flush_req = 1'b0;
        #3 rst_n = 1'b1;
        step();
        n_tests++;
        if (stall !== 1'b0 || en !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got stall=%b en=%b done=%b, want 0 0 0", stall, en, done);
        end
    endtask

    // flush at T with no drain wait: beats T+2..T+5, done T+6, stall T+1..T+6.
    task automatic test_basic();
        logic exp_en, exp_done, exp_stall;
        int   exp_base;
        logic [RW-1:0][PHY_REG_ID_WIDTH-1:0] exp_phy;
        flush_req = 1'b1;
        commit_inflight = 1'b0;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_stall: got %b want 0", stall);
        end
        step();
        flush_req = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            exp_en    = (c >= 2 && c <= 5);
            exp_base  = exp_en ? (c - 2) * RW : 0;
            exp_phy   = exp_en ? beat_ids(exp_base) : '0;
            exp_done  = (c == 6);
            exp_stall = (c <= 6);
            n_tests++;
            if (en !== exp_en || base !== ARCH_ID_WIDTH'(exp_base) || phy !== exp_phy ||
                done !== exp_done || stall !== exp_stall) begin
                n_fail++;
                $display("FAIL basic_cycle_T+%0d: got en=%b base=%0d phy0=%0d done=%b stall=%b, want en=%b base=%0d phy0=%0d done=%b stall=%b",
                         c, en, base, phy[0], done, stall, exp_en, exp_base, exp_phy[0], exp_done, exp_stall);
            end
            n_tests++;
            if (fp_en !== exp_en || fp_base !== ARCH_ID_WIDTH'(exp_base) || fp_done !== exp_done) begin
                n_fail++;
                $display("FAIL basic_fp_cycle_T+%0d: got en=%b base=%0d done=%b, want en=%b base=%0d done=%b",
                         c, fp_en, fp_base, fp_done, exp_en, exp_base, exp_done);
            end
            step();
        end
    endtask

    // commit_inflight held for 5 cycles after the flush delays the first beat.
    task automatic test_drain_hold();
        int done_seen;
        flush_req = 1'b1;
        commit_inflight = 1'b1;
        step();
        flush_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) commit_inflight = 1'b0;
            n_tests++;
            if (en !== 1'b0 || stall !== 1'b1 || base !== '0) begin
                n_fail++;
                $display("FAIL drain_hold_T+%0d: got en=%b stall=%b base=%0d, want en=0 stall=1 base=0", c, en, stall, base);
            end
            step();
        end
        n_tests++;
        if (en !== 1'b1 || base !== '0 || phy !== beat_ids(0)) begin
            n_fail++;
            $display("FAIL drain_first_beat: got en=%b base=%0d phy0=%0d, want en=1 base=0 phy0=40", en, base, phy[0]);
        end
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        n_tests++;
        if (done_seen != 1) begin
            n_fail++;
            $display("FAIL drain_done_count: got %0d want 1", done_seen);
        end
    endtask

    // Flush during beat 2 restarts from DRAIN with no done for the first sequence.
    task automatic test_reflush();
        flush_req = 1'b1;
        commit_inflight = 1'b0;
        step();
        flush_req = 1'b0;
        repeat (3) step();
        n_tests++;
        if (en !== 1'b1 || base !== ARCH_ID_WIDTH'(16)) begin
            n_fail++;
            $display("FAIL reflush_beat2: got en=%b base=%0d, want en=1 base=16", en, base);
        end
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        n_tests++;
        if (en !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reflush_drain: got en=%b stall=%b done=%b, want 0 1 0", en, stall, done);
        end
        step();
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if (en !== 1'b1 || base !== ARCH_ID_WIDTH'(b * RW) || phy !== beat_ids(b * RW) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reflush_restart_beat%0d: got en=%b base=%0d done=%b, want en=1 base=%0d done=0",
                         b, en, base, done, b * RW);
            end
            step();
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL reflush_done: got %b want 1", done);
        end
        repeat (2) step();
    endtask

    // Reset during beat 1 clears outputs immediately; no done afterwards.
    task automatic test_reset_mid_restore();
        int done_seen;
        flush_req = 1'b1;
        commit_inflight = 1'b0;
        step();
        flush_req = 1'b0;
        repeat (2) step();
        n_tests++;
        if (en !== 1'b1 || base !== ARCH_ID_WIDTH'(8)) begin
            n_fail++;
            $display("FAIL rst_mid_beat1: got en=%b base=%0d, want en=1 base=8", en, base);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({stall, en, base, phy, done} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got stall=%b en=%b base=%0d done=%b, want all 0", stall, en, base, done);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        n_tests++;
        if (stall !== 1'b0 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: got stall=%b en=%b, want 0 0", stall, en);
        end
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1 || en === 1'b1) done_seen++;
            step();
        end
        n_tests++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_abandon: got %0d done/beat cycles want 0", done_seen);
        end
        // First flush after reset behaves normally.
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_first_flush: got stall=%b want 1", stall);
        end
        repeat (5) step();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_first_flush_done: got %b want 1", done);
        end
        repeat (2) step();
    endtask

    // Repeated flushes while draining yield one sequence and one done.
    task automatic test_absorb();
        int done_seen;
        int beats_seen;
        flush_req = 1'b1;
        commit_inflight = 1'b1;
        step();
        step();
        step();
        flush_req = 1'b0;
        commit_inflight = 1'b0;
        done_seen = 0;
        beats_seen = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done === 1'b1) done_seen++;
            if (en === 1'b1) beats_seen++;
        end
        n_tests++;
        if (done_seen != 1) begin
            n_fail++;
            $display("FAIL absorb_done_count: got %0d want 1", done_seen);
        end
        n_tests++;
        if (beats_seen != 4) begin
            n_fail++;
            $display("FAIL absorb_beat_count: got %0d want 4", beats_seen);
        end
    endtask

`ifdef TOY_RECOVER_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            flush_req = 1'b1;
            step();
            flush_req = 1'b0;
            repeat (8) step();
        end
        n_tests++;
        if (perf_flush !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_flush_cnt: got %0d want 2", perf_flush);
        end
        n_tests++;
        if (perf_stall !== 32'd12) begin
            n_fail++;
            $display("FAIL perf_stall_cycles: got %0d want 12", perf_stall);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_drain_hold();
        test_reflush();
        test_reset_mid_restore();
        test_absorb();
`ifdef TOY_RECOVER_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
